// File: rtl/vx_dispatch_first.sv
// vx_dispatch_first
//   Buffers upstream beats in a 2-entry FIFO and dispatches the head beat
//   to exactly one eligible output lane per cycle. The eligible lanes are
//   those with both ready_out and lane_mask set. Priority goes to the
//   lowest lane index, or to the highest when REVERSE=1.
//
// Ports
//   clk, reset_n          clock; asynchronous active-low reset
//   valid_in/data_in      upstream beat
//   ready_in              upstream accept (driven from registers only)
//   lane_mask[N]          per-lane dispatch enable
//   valid_out[N]          per-lane valid, one-hot or zero
//   data_out[N][DATAW]    head payload, broadcast to every lane
//   ready_out[N]          per-lane accept
//   sel_out               index of the dispatched lane, 0 when idle
//   count_out             buffer occupancy, 0..2
module vx_dispatch_first #(
  parameter int N       = 1,
  parameter int DATAW   = 1,
  parameter int REVERSE = 0,
  localparam int SELW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid_in,
  input  logic [DATAW-1:0]          data_in,
  output logic                      ready_in,
  input  logic [N-1:0]              lane_mask,
  output logic [N-1:0]              valid_out,
  output logic [N-1:0][DATAW-1:0]   data_out,
  input  logic [N-1:0]              ready_out,
  output logic [SELW-1:0]           sel_out,
  output logic [1:0]                count_out
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_rst_done;
  logic [DATAW-1:0] r_buf0;   // head entry
  logic [DATAW-1:0] r_buf1;   // second entry, valid only in FULL

  logic [N-1:0]     w_elig;
  logic [SELW-1:0]  w_sel;
  logic [N-1:0]     w_onehot;
  logic             w_enq, w_deq;

  // Ready depends only on state registers, so upstream never sees a
  // combinational path from the downstream side.
  assign ready_in = r_rst_done && (r_state != FULL);
  assign w_enq    = valid_in && ready_in;

  assign w_elig   = ready_out & lane_mask;
  assign w_deq    = (r_state != EMPTY) && (w_elig != '0);

  // Priority pick: the last assignment wins, so scan toward the preferred end.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (REVERSE != 0) begin
        if (w_elig[i]) w_sel = SELW'(i);
      end else if (w_elig[N-1-i]) begin
        w_sel = SELW'(N-1-i);
      end
    end
  end

  assign w_onehot  = N'(1) << w_sel;
  assign sel_out   = w_deq ? w_sel : '0;
  assign count_out = r_state;

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign valid_out[k] = w_deq && w_onehot[k];
    assign data_out[k]  = r_buf0;
  end

  always_comb begin
    w_state_nxt = r_state;
    case ({w_enq, w_deq})
      2'b10: begin
        case (r_state)
          EMPTY:   w_state_nxt = ONE;
          ONE:     w_state_nxt = FULL;
          default: w_state_nxt = r_state;
        endcase
      end
      2'b01: begin
        case (r_state)
          FULL:    w_state_nxt = ONE;
          ONE:     w_state_nxt = EMPTY;
          default: w_state_nxt = r_state;
        endcase
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= EMPTY;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rst_done <= 1'b1;
    end
  end

  // Head always lives in r_buf0; a dequeue shifts r_buf1 forward.
  // A simultaneous enqueue and dequeue can only occur in ONE, as ready_in is low in FULL.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
    end else if (w_enq && !w_deq) begin
      if (r_state == EMPTY) r_buf0 <= data_in;
      else                  r_buf1 <= data_in;
    end else if (!w_enq && w_deq) begin
      r_buf0 <= r_buf1;
    end else if (w_enq && w_deq) begin
      r_buf0 <= data_in;
    end
  end

endmodule

// File: doc/vx_dispatch_first.md
VX_DISPATCH_FIRST -- requirements
Module: vx_dispatch_first

Interface
REQ-001 SHALL have parameter N, default 1: number of output lanes, N >= 1.
REQ-002 SHALL have parameter DATAW, default 1: payload width in bits.
REQ-003 SHALL have parameter REVERSE, default 0: 0 gives priority to the lowest lane index, 1 to the highest.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous assertion, active-low.
REQ-006 SHALL have port valid_in, input, 1: upstream beat valid.
REQ-007 SHALL have port data_in, input, DATAW: upstream payload.
REQ-008 SHALL have port ready_in, output, 1: upstream accept.
REQ-009 SHALL have port lane_mask, input, N: per-lane dispatch enable.
REQ-010 SHALL have port valid_out, output, N: per-lane beat valid.
REQ-011 SHALL have port data_out, output, N x DATAW: per-lane payload.
REQ-012 SHALL have port ready_out, input, N: per-lane accept.
REQ-013 SHALL have port sel_out, output, max(1, ceil(log2 N)): index of the lane being dispatched.
REQ-014 SHALL have port count_out, output, 2: buffer occupancy, 0..2.

Function
REQ-015 SHALL hold accepted beats in a 2-entry FIFO buffer with occupancy count in {0,1,2}, named states EMPTY, ONE and FULL.
REQ-016 SHALL define the upstream handshake as: enqueue = valid_in && ready_in.
REQ-017 SHALL drive ready_in = rst_done && (count != 2), from registers only, with no combinational path from ready_out, lane_mask or valid_in.
REQ-018 SHALL define rst_done as a register that is cleared by reset and set on the first clk edge after reset_n deasserts.
REQ-019 SHALL form the eligible set E = ready_out & lane_mask.
REQ-020 SHALL select lane f as the lowest set index of E (highest if REVERSE=1), chosen combinationally in the same cycle.
REQ-021 SHALL assert valid_out[k] = (count != 0) && (E != 0) && (k == f); valid_out is therefore one-hot or zero.
REQ-022 SHALL broadcast the head-entry payload on data_out[k] for every k, whether or not that lane's valid_out is asserted.
REQ-023 SHALL dequeue the head when any valid_out[k] && ready_out[k] (dequeue = (count != 0) && (E != 0)).
REQ-024 SHALL drive sel_out = f when a valid_out bit is asserted, else 0.
REQ-025 SHALL update count next = count + enqueue - dequeue; with enqueue and dequeue together, count SHALL stay the same.
REQ-026 SHALL make an enqueue into EMPTY visible on valid_out the next cycle (latency 1, no bypass).
REQ-027 SHALL sustain 1 beat per cycle when E stays nonzero, and SHALL preserve FIFO order across lanes.
REQ-028 SHALL ignore valid_in when ready_in is 0 and SHALL leave its state unchanged.
REQ-029 SHALL take effect of a lane_mask or ready_out change in the same cycle; valid_out stability is not guaranteed across cycles while E changes.
REQ-030 SHALL hold the head entry with valid_out all zero while E == 0, with no data loss.
REQ-031 SHALL, for N=1, reduce to a 2-entry buffer with sel_out constant 0.

Reset
REQ-032 SHALL, while reset_n is low, asynchronously force count=0, rst_done=0, ready_in=0, valid_out=0, sel_out=0, count_out=0, and both buffer entries to 0.
REQ-033 SHALL discard buffered beats if reset asserts mid-stream; no valid_out SHALL be asserted until a new beat is enqueued after rst_done=1.

Verification
REQ-034 SHALL verify reset release: reset_n low for 3 cycles, then high -> ready_in=0 during reset and on the first edge after release, 1 from the second edge, and valid_out=0 throughout.
REQ-035 SHALL verify priority: N=4, REVERSE=0, lane_mask=4'b1111, ready_out=4'b0110, enqueue 0xA5 -> the next cycle valid_out=4'b0010, sel_out=1, data_out[*]=0xA5; with REVERSE=1 -> valid_out=4'b0100, sel_out=2.
REQ-036 SHALL verify backpressure: ready_out=0, enqueue 3 beats back to back -> count_out reaches 2, ready_in=0, the third beat is not accepted and is held upstream; setting ready_out[3]=1 -> beats drain to lane 3 in order, one per cycle.
REQ-037 SHALL verify masking: ready_out=4'b1111, lane_mask=4'b1100 -> dispatch on lane 2 only; lane_mask=0 -> valid_out=0 and the head is held.
REQ-038 SHALL verify streaming: continuous valid_in with 100 incrementing values and a random nonzero E -> 100 beats out in order, zero loss or duplication, throughput 1/cycle whenever E != 0, and valid_out one-hot0 every cycle.
REQ-039 SHALL verify mid-stream reset: count_out=2, assert reset_n low -> the same cycle count_out=0 and valid_out=0, and no stale data appears after release.
